// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared parameters and state encoding for the mux scan sequencer
// Purpose : default sizing for the scanner and the FSM state type used by
//           mux_scan_ctrl.
// Contents: DEF_N_CH / DEF_SEL_W / DEF_SETTLE / DEF_CNT_W defaults, state_t.
package mux_scan_ctrl_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_next_ch_find.sv
// rtl/mux_scan_ctrl_next_ch_find.sv - combinational next-enabled-channel finder
// Purpose : returns the lowest set bit of i_mask (i_first=1) or the lowest
//           set bit strictly above i_cur (i_first=0).
// Ports   : i_mask  [N_CH]  channel enable mask
//           i_cur   [SEL_W] current channel index
//           i_first         1 = search from bit 0, ignore i_cur
//           o_idx   [SEL_W] found channel index (0 when none)
//           o_found         a qualifying set bit exists
module mux_scan_ctrl_next_ch_find #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  i_mask,
  input  logic [SEL_W-1:0] i_cur,
  input  logic             i_first,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  // Walk from the top down so the lowest qualifying bit is the last writer.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (SEL_W'(i) > i_cur))) begin
        o_idx   = SEL_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequencer scanning a 4:1 mux into a per-channel snapshot
// Purpose : drives mux select o_s over the enabled channels, holds each for a
//           settle interval, samples i_y once per channel and publishes the
//           assembled snapshot with a one-cycle o_valid pulse. One-shot or
//           continuous scanning.
// Ports   : i_clk, i_reset (async, active-high)
//           i_start       scan request, honoured only in IDLE
//           i_continuous  rescan after each snapshot (looked at in DONE)
//           i_ch_en [N]   channel enable mask, latched at scan start
//           i_y           shared mux output
//           o_s [SEL_W]   mux select
//           o_sample [N]  last complete snapshot
//           o_valid       o_sample updated this cycle
//           o_busy        state != IDLE
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_continuous,
  input  logic [N_CH-1:0]  i_ch_en,
  input  logic             i_y,
  output logic [SEL_W-1:0] o_s,
  output logic [N_CH-1:0]  o_sample,
  output logic             o_valid,
  output logic             o_busy
);

  state_t           r_state,  w_state_nxt;
  logic [SEL_W-1:0] r_s,      w_s_nxt;
  logic [N_CH-1:0]  r_mask,   w_mask_nxt;
  logic [N_CH-1:0]  r_shadow, w_shadow_nxt;
  logic [N_CH-1:0]  r_sample, w_sample_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic             r_valid,  w_valid_nxt;
  logic             r_busy;

  logic [N_CH-1:0]  w_find_mask;
  logic             w_find_first;
  logic [SEL_W-1:0] w_find_idx;
  logic             w_find_found;

  // One finder serves both uses: in SAMPLE it steps through the latched mask
  // above the current channel; elsewhere it looks at the live enable input,
  // which is exactly the mask about to be latched in IDLE/DONE.
  assign w_find_mask  = (r_state == ST_SAMPLE) ? r_mask : i_ch_en;
  assign w_find_first = (r_state != ST_SAMPLE);

  mux_scan_ctrl_next_ch_find #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next_ch_find (
    .i_mask  (w_find_mask),
    .i_cur   (r_s),
    .i_first (w_find_first),
    .o_idx   (w_find_idx),
    .o_found (w_find_found)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_mask_nxt   = r_mask;
    w_shadow_nxt = r_shadow;
    w_sample_nxt = r_sample;
    w_cnt_nxt    = r_cnt;
    w_valid_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_mask_nxt   = i_ch_en;
          w_shadow_nxt = '0;
          if (w_find_found) begin
            w_s_nxt     = w_find_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_SETTLE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(SETTLE - 1)) begin
          w_state_nxt = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        w_shadow_nxt[r_s] = i_y;
        if (w_find_found) begin
          w_s_nxt     = w_find_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        w_sample_nxt = r_shadow;
        w_valid_nxt  = 1'b1;
        w_state_nxt  = ST_IDLE;
        if (i_continuous) begin
          w_mask_nxt   = i_ch_en;
          w_shadow_nxt = '0;
          if (w_find_found) begin
            w_s_nxt     = w_find_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SETTLE;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
      r_sample <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_mask   <= w_mask_nxt;
      r_shadow <= w_shadow_nxt;
      r_sample <= w_sample_nxt;
      r_cnt    <= w_cnt_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_s      = r_s;
  assign o_sample = r_sample;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a behavioural mux
module tb_mux_scan_ctrl;

  localparam int T_SETTLE = 2;
  localparam int T_SLOT   = T_SETTLE + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       continuous;
  logic [3:0] ch_en;
  logic [3:0] in_pat;
  logic       y;
  logic [1:0] s;
  logic [3:0] sample;
  logic       valid;
  logic       busy;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [1:0] exp_last_s;

  int         obs_valid_edge;
  int         obs_busy_cnt;
  logic [3:0] obs_sample;
  logic [1:0] obs_s[$];

  always #5 clk = ~clk;

  // Behavioural 4:1 mux: the selected input appears on y.
  assign y = in_pat[s];

  mux_scan_ctrl dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_continuous (continuous),
    .i_ch_en      (ch_en),
    .i_y          (y),
    .o_s          (s),
    .o_sample     (sample),
    .o_valid      (valid),
    .o_busy       (busy)
  );

  // Stimulus driver: pulses start, then records s every cycle until valid.
  // Edge 0 is the edge that captures start. Optionally re-pulses start with a
  // different mask after edge poke_edge.
  task automatic run_scan(input logic [3:0] m, input int poke_edge, input logic [3:0] poke_mask);
    obs_s.delete();
    obs_valid_edge = -1;
    obs_busy_cnt   = 0;
    obs_sample     = 'x;
    ch_en = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e < 60; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      if (e == poke_edge) begin
        start = 1'b1;
        ch_en = poke_mask;
      end else if (e == poke_edge + 1) begin
        start = 1'b0;
      end
      if (busy) obs_busy_cnt++;
      if (valid) begin
        obs_valid_edge = e;
        obs_sample     = sample;
        break;
      end
      obs_s.push_back(s);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; ch_en = 4'b0000; in_pat = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (s !== 2'd0)      $display("FAIL reset_s got %0d want 0", s);           else n_pass++;
    n_total++; if (sample !== 4'd0) $display("FAIL reset_sample got %b want 0000", sample); else n_pass++;
    n_total++; if (valid !== 1'b0)  $display("FAIL reset_valid got %b want 0", valid);     else n_pass++;
    n_total++; if (busy !== 1'b0)   $display("FAIL reset_busy got %b want 0", busy);       else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    exp_last_s = 2'd0;
  endtask

  task automatic test_one_shot(input string name, input logic [3:0] m, input logic [3:0] pat,
                               input int poke_edge, input logic [3:0] poke_mask);
    int         k;
    int         exp_edge;
    logic [1:0] hold;
    logic [1:0] exp_trace[$];
    int         bad_at;

    in_pat     = pat;
    continuous = 1'b0;
    k          = 0;
    hold       = exp_last_s;
    exp_trace.delete();
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        k++;
        hold = 2'(i);
        for (int j = 0; j < T_SLOT; j++) exp_trace.push_back(2'(i));
      end
    end
    exp_trace.push_back(hold);
    exp_edge = k * T_SLOT + 1;

    run_scan(m, poke_edge, poke_mask);

    n_total++;
    if (obs_valid_edge !== exp_edge)
      $display("FAIL %s valid_edge got %0d want %0d", name, obs_valid_edge, exp_edge);
    else n_pass++;

    n_total++;
    if (obs_sample !== (m & pat))
      $display("FAIL %s sample got %b want %b", name, obs_sample, m & pat);
    else n_pass++;

    n_total++;
    if (obs_busy_cnt !== exp_edge)
      $display("FAIL %s busy_cycles got %0d want %0d", name, obs_busy_cnt, exp_edge);
    else n_pass++;

    bad_at = -1;
    if (obs_s.size() != exp_trace.size()) bad_at = 999;
    else
      for (int e = 0; e < exp_trace.size(); e++)
        if (bad_at < 0 && obs_s[e] !== exp_trace[e]) bad_at = e;
    n_total++;
    if (bad_at >= 0)
      $display("FAIL %s s_trace first bad edge %0d (len got %0d want %0d)",
               name, bad_at, obs_s.size(), exp_trace.size());
    else n_pass++;

    @(posedge clk); #1;
    n_total++;
    if (s !== hold) $display("FAIL %s s_hold got %0d want %0d", name, s, hold);
    else n_pass++;

    n_total++;
    if (valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after_valid valid=%b busy=%b want 0 0", name, valid, busy);
    else n_pass++;

    exp_last_s = hold;
  endtask

  task automatic test_reset_mid_scan();
    bit seen_valid;
    in_pat = 4'b1111; continuous = 1'b0;
    ch_en  = 4'b1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_total++; if (s !== 2'd0)      $display("FAIL midreset_s got %0d want 0", s);           else n_pass++;
    n_total++; if (busy !== 1'b0)   $display("FAIL midreset_busy got %b want 0", busy);       else n_pass++;
    n_total++; if (sample !== 4'd0) $display("FAIL midreset_sample got %b want 0000", sample); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid || busy) seen_valid = 1'b1;
    end
    n_total++;
    if (seen_valid) $display("FAIL midreset_quiet got activity want none");
    else n_pass++;
    exp_last_s = 2'd0;
  endtask

  task automatic test_continuous();
    int         v_edge[$];
    logic [3:0] v_samp[$];
    bit         extra;
    bit         busy_after;
    in_pat = 4'b0011; ch_en = 4'b1111; continuous = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_after = 1'b1;
    for (int e = 0; e < 120 && v_edge.size() < 3; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      if (valid) begin
        v_edge.push_back(e);
        v_samp.push_back(sample);
        if (v_edge.size() == 1) in_pat = 4'b1100;
        if (v_edge.size() == 2) continuous = 1'b0;
        if (v_edge.size() == 3) busy_after = busy;
      end
    end
    while (v_edge.size() < 3) begin
      v_edge.push_back(-1);
      v_samp.push_back('x);
    end
    for (int n = 0; n < 3; n++) begin
      n_total++;
      if (v_edge[n] !== (n + 1) * (4 * T_SLOT + 1))
        $display("FAIL cont_edge%0d got %0d want %0d", n, v_edge[n], (n + 1) * (4 * T_SLOT + 1));
      else n_pass++;
    end
    n_total++; if (v_samp[0] !== 4'b0011) $display("FAIL cont_snap0 got %b want 0011", v_samp[0]); else n_pass++;
    n_total++; if (v_samp[1] !== 4'b1100) $display("FAIL cont_snap1 got %b want 1100", v_samp[1]); else n_pass++;
    n_total++; if (v_samp[2] !== 4'b1100) $display("FAIL cont_snap2 got %b want 1100", v_samp[2]); else n_pass++;
    n_total++; if (busy_after !== 1'b0) $display("FAIL cont_stop_busy got %b want 0", busy_after); else n_pass++;
    extra = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (valid || busy) extra = 1'b1;
    end
    n_total++; if (extra) $display("FAIL cont_stopped got activity want idle"); else n_pass++;
    exp_last_s = 2'd3;
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic [3:0] p;
    for (int n = 0; n < 8; n++) begin
      m = 4'($urandom_range(0, 15));
      p = 4'($urandom);
      test_one_shot("random", m, p, -5, 4'b0000);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot("full_scan",       4'b1111, 4'b1010, -5, 4'b0000);
    test_one_shot("sparse_scan",     4'b0101, 4'b1111, -5, 4'b0000);
    test_one_shot("empty_mask",      4'b0000, 4'b1111, -5, 4'b0000);
    test_reset_mid_scan();
    test_continuous();
    test_one_shot("restart_ignored", 4'b0110, 4'b0100,  4, 4'b1001);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
